// File: rtl/icache_pf_if.sv
// Processor and memory-side bus of the instruction cache with next-line prefetch.
// The slave modport is the cache; the master modport is the processor/memory environment.
interface icache_pf_if;
  logic         proc_read;
  logic         proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic         proc_stall;
  logic [31:0]  proc_rdata;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_rdata;
  logic [127:0] mem_wdata;
  logic         mem_ready;
  logic [15:0]  stat_miss;

  modport slave (
    input  proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
    output proc_stall, proc_rdata, mem_read, mem_write, mem_addr, mem_wdata, stat_miss
  );

  modport master (
    output proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
    input  proc_stall, proc_rdata, mem_read, mem_write, mem_addr, mem_wdata, stat_miss
  );
endinterface

// File: rtl/icache_pf.sv
// Read-only set-associative instruction cache (1 or 2 ways, LRU) with a one-line
// next-line prefetch buffer and a single outstanding memory request.
module icache_pf #(
  parameter int SETS        = 4,
  parameter int WAYS        = 2,
  parameter int PREFETCH_EN = 1
) (
  input logic        clk,
  input logic        proc_reset,
  icache_pf_if.slave bus
);
  localparam int IDX   = $clog2(SETS);
  localparam int TAG_W = 28 - IDX;

  typedef enum logic [1:0] {IDLE, FILL, PREFETCH} state_t;

  state_t           state_q, state_d;
  logic [127:0]     data_q  [SETS][WAYS];
  logic [TAG_W-1:0] tag_q   [SETS][WAYS];
  logic [WAYS-1:0]  valid_q [SETS];
  logic [SETS-1:0]  lru_q;  // per set: index of the least recently used way
  logic [127:0]     buf_data_q;
  logic [27:0]      buf_addr_q;
  logic             buf_valid_q;
  logic [27:0]      fill_line_q, fill_line_d;
  logic [27:0]      pf_line_q, pf_line_d;
  logic [15:0]      stat_miss_q;

  logic [27:0]      req_line;
  logic [IDX-1:0]   req_set;
  logic [TAG_W-1:0] req_tag;
  logic [1:0]       req_word;
  logic [IDX-1:0]   fill_set;

  assign req_line = bus.proc_addr[29:2];
  assign req_set  = bus.proc_addr[IDX+1:2];
  assign req_tag  = bus.proc_addr[29:IDX+2];
  assign req_word = bus.proc_addr[1:0];
  assign fill_set = fill_line_q[IDX-1:0];

  // Writes are not supported by this cache; these inputs are intentionally ignored.
  wire unused_write = &{1'b0, bus.proc_write, bus.proc_wdata};

  function automatic logic [31:0] word_sel(input logic [127:0] line, input logic [1:0] off);
    return line[off*32 +: 32];
  endfunction

  function automatic logic victim_sel(input logic [WAYS-1:0] v, input logic lru);
    if (WAYS == 1 || !v[0]) return 1'b0;
    if (!v[WAYS-1])         return 1'b1;
    return lru;
  endfunction

  logic cache_hit, hit_way, buf_hit;

  always_comb begin
    cache_hit = 1'b0;
    hit_way   = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[req_set][w] && tag_q[req_set][w] == req_tag) begin
        cache_hit = 1'b1;
        hit_way   = 1'(w);
      end
    end
  end

  assign buf_hit = buf_valid_q && (buf_addr_q == req_line);

  logic             line_we, line_way;
  logic [IDX-1:0]   line_set;
  logic [TAG_W-1:0] line_tag;
  logic [127:0]     line_data;
  logic             lru_we, lru_mru;
  logic [IDX-1:0]   lru_set;
  logic             buf_inval, buf_load, miss_inc;
  logic             stall, mem_rd;
  logic [31:0]      rdata;
  logic [27:0]      maddr;

  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    fill_line_d = fill_line_q;
    pf_line_d   = pf_line_q;
    stall       = 1'b0;
    rdata       = '0;
    mem_rd      = 1'b0;
    maddr       = '0;
    line_we     = 1'b0;
    line_way    = 1'b0;
    line_set    = req_set;
    line_tag    = req_tag;
    line_data   = buf_data_q;
    lru_we      = 1'b0;
    lru_set     = req_set;
    lru_mru     = hit_way;
    buf_inval   = 1'b0;
    buf_load    = 1'b0;
    miss_inc    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.proc_read) begin
          if (cache_hit) begin
            rdata  = word_sel(data_q[req_set][hit_way], req_word);
            lru_we = 1'b1;
          end else if (buf_hit) begin
            rdata     = word_sel(buf_data_q, req_word);
            line_we   = 1'b1;
            line_way  = victim_sel(valid_q[req_set], lru_q[req_set]);
            lru_we    = 1'b1;
            lru_mru   = line_way;
            buf_inval = 1'b1;
            if (PREFETCH_EN != 0) begin
              state_d   = PREFETCH;
              pf_line_d = req_line + 28'd1;
            end
          end else begin
            stall       = 1'b1;
            mem_rd      = 1'b1;
            maddr       = req_line;
            fill_line_d = req_line;
            state_d     = FILL;
          end
        end
      end

      FILL: begin
        mem_rd = 1'b1;
        maddr  = fill_line_q;
        stall  = 1'b1;
        if (bus.mem_ready) begin
          stall     = 1'b0;
          rdata     = bus.proc_read ? word_sel(bus.mem_rdata, req_word) : 32'd0;
          line_we   = 1'b1;
          line_set  = fill_set;
          line_tag  = fill_line_q[27:IDX];
          line_data = bus.mem_rdata;
          line_way  = victim_sel(valid_q[fill_set], lru_q[fill_set]);
          lru_we    = 1'b1;
          lru_set   = fill_set;
          lru_mru   = line_way;
          miss_inc  = 1'b1;
          pf_line_d = fill_line_q + 28'd1;
          state_d   = (PREFETCH_EN != 0) ? PREFETCH : IDLE;
        end
      end

      PREFETCH: begin
        mem_rd = 1'b1;
        maddr  = pf_line_q;
        if (bus.proc_read) begin
          if (cache_hit) begin
            rdata  = word_sel(data_q[req_set][hit_way], req_word);
            lru_we = 1'b1;
          end else begin
            // Misses wait for the prefetch, then get re-evaluated from IDLE.
            stall = 1'b1;
          end
        end
        if (bus.mem_ready) begin
          buf_load = 1'b1;
          state_d  = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    if (proc_reset) begin
      stall  = 1'b0;
      rdata  = '0;
      mem_rd = 1'b0;
      maddr  = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      state_q     <= IDLE;
      for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
      lru_q       <= '0;
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
      fill_line_q <= '0;
      pf_line_q   <= '0;
      stat_miss_q <= '0;
    end else begin
      state_q     <= state_d;
      fill_line_q <= fill_line_d;
      pf_line_q   <= pf_line_d;
      if (line_we) valid_q[line_set][line_way] <= 1'b1;
      if (lru_we && WAYS == 2) lru_q[lru_set] <= ~lru_mru;
      if (buf_load) begin
        buf_valid_q <= 1'b1;
        buf_addr_q  <= pf_line_q;
      end else if (buf_inval) begin
        buf_valid_q <= 1'b0;
      end
      if (miss_inc && stat_miss_q != 16'hFFFF) stat_miss_q <= stat_miss_q + 16'd1;
    end
  end

  // NOTE: data and tag storage is not reset; the valid bits alone qualify its contents.
  always_ff @(posedge clk) begin
    if (line_we) begin
      data_q[line_set][line_way] <= line_data;
      tag_q[line_set][line_way]  <= line_tag;
    end
    if (buf_load) buf_data_q <= bus.mem_rdata;
  end

  assign bus.proc_stall = stall;
  assign bus.proc_rdata = rdata;
  assign bus.mem_read   = mem_rd;
  assign bus.mem_addr   = maddr;
  assign bus.mem_write  = 1'b0;
  assign bus.mem_wdata  = '0;
  assign bus.stat_miss  = stat_miss_q;
endmodule

// File: tb/tb_icache_pf.sv
// Self-checking bench for icache_pf: directed scenarios followed by random traffic,
// compared against a line-level model (MRU-ordered residency lists plus a prefetch buffer).
module tb_icache_pf;
  logic clk = 1'b0;
  logic proc_reset;
  always #5 clk = ~clk;

  icache_pf_if bus();

  icache_pf #(.SETS(4), .WAYS(2), .PREFETCH_EN(1)) dut (
    .clk       (clk),
    .proc_reset(proc_reset),
    .bus       (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: per set, resident lines ordered most- to least-recently used.
  logic [27:0] res_q [4][$];
  logic        m_buf_valid;
  logic [27:0] m_buf_line;
  logic        m_pf_pending;
  logic [27:0] m_pf_line;
  int          m_stat;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [27:0] line, input logic [1:0] w);
    if (line == 28'h4) begin
      case (w)
        2'd0:    return 32'h0000_AAAA;
        2'd1:    return 32'h0000_BBBB;
        2'd2:    return 32'h0000_CCCC;
        default: return 32'h0000_DDDD;
      endcase
    end
    return {line, w, 2'b00} ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [127:0] mem_line(input logic [27:0] line);
    return {mem_word(line, 2'd3), mem_word(line, 2'd2), mem_word(line, 2'd1), mem_word(line, 2'd0)};
  endfunction

  function automatic bit resident(input logic [27:0] line);
    int s = int'(line[1:0]);
    for (int i = 0; i < res_q[s].size(); i++)
      if (res_q[s][i] == line) return 1'b1;
    return 1'b0;
  endfunction

  task automatic touch(input logic [27:0] line);
    int s = int'(line[1:0]);
    for (int i = 0; i < res_q[s].size(); i++) begin
      if (res_q[s][i] == line) begin
        res_q[s].delete(i);
        break;
      end
    end
    res_q[s].push_front(line);
  endtask

  task automatic insert(input logic [27:0] line);
    int s = int'(line[1:0]);
    if (res_q[s].size() >= 2) void'(res_q[s].pop_back());
    res_q[s].push_front(line);
  endtask

  task automatic model_reset();
    for (int s = 0; s < 4; s++) res_q[s].delete();
    m_buf_valid  = 1'b0;
    m_buf_line   = '0;
    m_pf_pending = 1'b0;
    m_pf_line    = '0;
    m_stat       = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    proc_reset = 1'b1;
    @(negedge clk);
    tick();
    proc_reset = 1'b0;
    model_reset();
  endtask

  // Background prefetch completes while the processor is quiet.
  task automatic drain();
    if (m_pf_pending) begin
      bus.proc_read  = 1'b0;
      bus.mem_ready  = 1'b1;
      bus.mem_rdata  = mem_line(m_pf_line);
      @(negedge clk);
      check("drain_mem_read", bus.mem_read, 1);
      check("drain_mem_addr", bus.mem_addr, m_pf_line);
      check("drain_stall", bus.proc_stall, 0);
      tick();
      bus.mem_ready = 1'b0;
      bus.mem_rdata = '0;
      m_buf_valid   = 1'b1;
      m_buf_line    = m_pf_line;
      m_pf_pending  = 1'b0;
    end
  endtask

  task automatic idle_cycle();
    bus.proc_read  = 1'b0;
    bus.proc_write = 1'b0;
    @(negedge clk);
    check("idle_mem_read", bus.mem_read, m_pf_pending);
    check("idle_stall", bus.proc_stall, 0);
    check("idle_rdata", bus.proc_rdata, 0);
    tick();
  endtask

  task automatic write_op(input logic [29:0] addr);
    bus.proc_read  = 1'b0;
    bus.proc_write = 1'b1;
    bus.proc_addr  = addr;
    bus.proc_wdata = $urandom;
    @(negedge clk);
    check("wr_stall", bus.proc_stall, 0);
    check("wr_mem_write", bus.mem_write, 0);
    check("wr_mem_wdata", bus.mem_wdata, 0);
    check("wr_mem_read", bus.mem_read, m_pf_pending);
    tick();
    bus.proc_write = 1'b0;
  endtask

  task automatic read_op(input logic [29:0] addr, output bit demand);
    logic [27:0] line;
    int d;
    line   = addr[29:2];
    demand = 1'b0;
    bus.proc_read  = 1'b1;
    bus.proc_write = 1'b0;
    bus.proc_addr  = addr;
    if (m_pf_pending && !resident(line)) begin
      d = $urandom_range(0, 3);
      for (int i = 0; i < d; i++) begin
        @(negedge clk);
        check("pf_wait_stall", bus.proc_stall, 1);
        check("pf_wait_addr", bus.mem_addr, m_pf_line);
        check("pf_wait_read", bus.mem_read, 1);
        tick();
      end
      bus.mem_ready = 1'b1;
      bus.mem_rdata = mem_line(m_pf_line);
      @(negedge clk);
      check("pf_ready_stall", bus.proc_stall, 1);
      check("pf_ready_addr", bus.mem_addr, m_pf_line);
      tick();
      bus.mem_ready = 1'b0;
      bus.mem_rdata = '0;
      m_buf_valid   = 1'b1;
      m_buf_line    = m_pf_line;
      m_pf_pending  = 1'b0;
    end
    @(negedge clk);
    if (resident(line)) begin
      check("hit_stall", bus.proc_stall, 0);
      check("hit_rdata", bus.proc_rdata, mem_word(line, addr[1:0]));
      touch(line);
      tick();
    end else if (m_buf_valid && m_buf_line == line) begin
      check("buf_stall", bus.proc_stall, 0);
      check("buf_rdata", bus.proc_rdata, mem_word(line, addr[1:0]));
      check("buf_mem_read", bus.mem_read, 0);
      tick();
      insert(line);
      m_buf_valid  = 1'b0;
      m_pf_pending = 1'b1;
      m_pf_line    = line + 28'd1;
    end else begin
      demand = 1'b1;
      check("miss_stall", bus.proc_stall, 1);
      check("miss_mem_read", bus.mem_read, 1);
      check("miss_mem_addr", bus.mem_addr, line);
      tick();
      d = $urandom_range(0, 3);
      for (int i = 0; i < d; i++) begin
        @(negedge clk);
        check("fill_stall", bus.proc_stall, 1);
        check("fill_mem_addr", bus.mem_addr, line);
        tick();
      end
      bus.mem_ready = 1'b1;
      bus.mem_rdata = mem_line(line);
      @(negedge clk);
      check("fill_done_stall", bus.proc_stall, 0);
      check("fill_done_rdata", bus.proc_rdata, mem_word(line, addr[1:0]));
      tick();
      bus.mem_ready = 1'b0;
      bus.mem_rdata = '0;
      insert(line);
      m_stat++;
      m_pf_pending = 1'b1;
      m_pf_line    = line + 28'd1;
    end
    bus.proc_read = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit dm;
    logic [29:0] a;
    int op;

    bus.proc_read  = 1'b0;
    bus.proc_write = 1'b0;
    bus.proc_addr  = '0;
    bus.proc_wdata = '0;
    bus.mem_ready  = 1'b0;
    bus.mem_rdata  = '0;
    model_reset();

    // Outputs held quiet under reset even with a request present.
    proc_reset     = 1'b1;
    bus.proc_read  = 1'b1;
    bus.proc_addr  = 30'h010;
    @(negedge clk);
    check("rst_stall", bus.proc_stall, 0);
    check("rst_rdata", bus.proc_rdata, 0);
    check("rst_mem_read", bus.mem_read, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_stat", bus.stat_miss, 0);
    check("rst_mem_write", bus.mem_write, 0);
    tick();
    proc_reset    = 1'b0;
    bus.proc_read = 1'b0;

    // Cold miss and following prefetch address.
    read_op(30'h010, dm);
    check("cold_demand", dm, 1);
    @(negedge clk);
    check("cold_stat", bus.stat_miss, 1);
    check("cold_pf_addr", bus.mem_addr, 28'h5);
    tick();

    // Buffer hit on the prefetched line.
    drain();
    read_op(30'h016, dm);
    check("bufhit_demand", dm, 0);
    @(negedge clk);
    check("bufhit_stat", bus.stat_miss, 1);
    check("bufhit_pf_addr", bus.mem_addr, 28'h6);
    tick();

    // LRU replacement within set 0.
    do_reset();
    read_op(30'h000, dm);
    read_op(30'h010, dm);
    read_op(30'h000, dm);
    check("lru_touch_hit", dm, 0);
    read_op(30'h020, dm);
    check("lru_fill8_demand", dm, 1);
    read_op(30'h000, dm);
    check("lru_keep0", dm, 0);
    read_op(30'h010, dm);
    check("lru_evict4", dm, 1);
    check("lru_stat", bus.stat_miss, 4);

    // Prefetch address wraps at the top of the line space.
    read_op(30'h3FFF_FFFC, dm);
    check("wrap_demand", dm, 1);
    @(negedge clk);
    check("wrap_pf_addr", bus.mem_addr, 28'h0);
    tick();

    // Miss during prefetch, then reset mid-fill.
    read_op(30'h100, dm);
    check("pfmiss_demand", dm, 1);
    drain();
    bus.proc_read = 1'b1;
    bus.proc_addr = 30'h200;
    @(negedge clk);
    check("rf_miss_addr", bus.mem_addr, 28'h80);
    tick();
    @(negedge clk);
    check("rf_fill_read", bus.mem_read, 1);
    #2;
    proc_reset = 1'b1;
    #1;
    check("rf_rst_mem_read", bus.mem_read, 0);
    check("rf_rst_stall", bus.proc_stall, 0);
    check("rf_rst_mem_addr", bus.mem_addr, 0);
    tick();
    proc_reset    = 1'b0;
    bus.proc_read = 1'b0;
    model_reset();
    bus.mem_ready = 1'b1;
    bus.mem_rdata = mem_line(28'h80);
    @(negedge clk);
    check("stray_ready_read", bus.mem_read, 0);
    tick();
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    idle_cycle();
    check("stray_stat", bus.stat_miss, 0);
    read_op(30'h200, dm);
    check("after_rst_demand", dm, 1);
    check("after_rst_stat", bus.stat_miss, 1);

    // Random traffic over a small line pool to mix hits, buffer hits and evictions.
    for (int n = 0; n < 300; n++) begin
      a  = {28'($urandom_range(0, 15)), 2'($urandom)};
      op = $urandom_range(0, 8);
      if (op <= 5)      read_op(a, dm);
      else if (op == 6) write_op(a);
      else if (op == 7) drain();
      else              idle_cycle();
    end
    @(negedge clk);
    check("final_stat", bus.stat_miss, 16'(m_stat));
    check("final_mem_write", bus.mem_write, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/icache_pf.md
ICACHE_PF -- requirements
Module: icache_pf

Interface
REQ-001 The block SHALL have parameter SETS, default 4, number of sets (power of 2, 2..64); IDX = log2(SETS).
REQ-002 The block SHALL have parameter WAYS, default 2, associativity (legal values 1 or 2).
REQ-003 The block SHALL have parameter PREFETCH_EN, default 1, enabling the next-line prefetch buffer.
REQ-004 Port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 Port proc_reset, input, 1 bit: reset, asynchronous and active-high.
REQ-006 Ports proc_read and proc_write, inputs, 1 bit each: processor read and write requests.
REQ-007 Port proc_addr, input, 30 bits: word address; [1:0] is the word offset, [IDX+1:2] is the set, [29:IDX+2] is the tag.
REQ-008 Port proc_wdata, input, 32 bits: unused.
REQ-009 Port proc_stall, output, 1 bit: processor must hold its request.
REQ-010 Port proc_rdata, output, 32 bits: read data.
REQ-011 Ports mem_read and mem_write, outputs, 1 bit each: memory request strobes.
REQ-012 Port mem_addr, output, 28 bits: line address, equal to proc_addr[29:2] for demand requests.
REQ-013 Ports mem_rdata (input, 128 bits) and mem_wdata (output, 128 bits): line data, with word0 in [31:0].
REQ-014 Port mem_ready, input, 1 bit: memory line valid, a single-cycle pulse.
REQ-015 Port stat_miss, output, 16 bits: saturating count of demand memory fills.

Function
REQ-016 Storage SHALL be SETS x WAYS lines, each 128-bit data plus tag plus valid bit, plus one LRU bit per set when WAYS=2.
REQ-017 Prefetch buffer SHALL be one 128-bit line with a 28-bit line address and a valid bit.
REQ-018 FSM SHALL have states IDLE, FILL and PREFETCH; the memory interface SHALL have at most one outstanding request.
REQ-019 mem_write SHALL be 0 and mem_wdata SHALL be 0 at all times; proc_write SHALL be ignored, with no stall and no state change.
REQ-020 IDLE, cache hit: proc_rdata SHALL be the selected word combinationally, proc_stall=0, and LRU SHALL mark the hit way as MRU at the edge.
REQ-021 IDLE, cache miss with buffer valid and buffer address == proc_addr[29:2]:
 - proc_rdata SHALL be the buffer word, proc_stall=0;
 - at the edge the line SHALL be written to the victim way and the buffer invalidated;
 - next state SHALL be PREFETCH of line+1 if PREFETCH_EN, else IDLE.
REQ-022 IDLE, other miss: proc_stall=1, mem_read=1, mem_addr=proc_addr[29:2], next state FILL.
REQ-023 FILL:
 - mem_read=1, mem_addr=demand line, proc_stall=1 until mem_ready;
 - on mem_ready: proc_rdata=mem_rdata word, proc_stall=0, line written to the victim way and marked MRU, stat_miss incremented (saturating at 0xFFFF);
 - next state PREFETCH if PREFETCH_EN, else IDLE.
REQ-024 Victim SHALL be the lowest-numbered invalid way, else the LRU way; with WAYS=1 it SHALL be way 0.
REQ-025 The prefetch address SHALL be the demand line address +1 modulo 2^28 (0xFFFFFFF wraps to 0x0000000), latched on entering PREFETCH.
REQ-026 PREFETCH:
 - mem_read=1, mem_addr=prefetch address;
 - processor hits SHALL be served with no stall;
 - a processor miss SHALL stall until mem_ready;
 - on mem_ready: buffer loaded and valid, next state IDLE, where a pending miss is re-evaluated the following cycle.
REQ-027 Cache hit SHALL take priority over buffer hit; a buffer whose line is also resident SHALL be left unchanged.
REQ-028 When proc_read=0, proc_rdata SHALL be 0 and LRU SHALL be unchanged.

Reset
REQ-029 On proc_reset assertion, asynchronously: state IDLE, all cache valid bits, LRU bits and the buffer valid bit cleared, stat_miss=0.
REQ-030 During reset the outputs SHALL be proc_stall=0, proc_rdata=0, mem_read=0 and mem_addr=0; data and tag arrays SHALL NOT require reset.
REQ-031 Reset mid-FILL or mid-PREFETCH SHALL abandon the request, and a mem_ready arriving afterwards SHALL be ignored in IDLE.

Verification (SETS=4, WAYS=2, PREFETCH_EN=1)
REQ-032 Cold miss: after reset, read 0x010 -> stall, mem_addr=0x0000004; mem_ready with rdata 0xDDDD_CCCC_BBBB_AAAA (32-bit words) -> proc_rdata=0xAAAA, stall drops, stat_miss=1, next cycle mem_addr=0x0000005.
REQ-033 Buffer hit: after the 0x5 prefetch returns, read 0x016 -> no stall, word2 of the buffer returned, stat_miss stays 1, then mem_addr=0x0000006.
REQ-034 LRU: fill lines 0x0, 0x4, touch 0x0, fill 0x8 (all set 0) -> line 0x4 evicted; subsequent read of 0x000 hits and read of 0x010 misses.
REQ-035 Wrap: demand miss on proc_addr 0x3FFFFFFC -> prefetch mem_addr=0x0000000.
REQ-036 Miss during PREFETCH stalls until the prefetch mem_ready, then FILL issues the demand address; proc_reset asserted mid-FILL -> mem_read=0 immediately, and a later read of the same address misses.
